// File: rtl/mpu6502_lite.sv
// mpu6502_lite: compact 6502-compatible core (vector fetch, implied, read/ALU, store).
// Optional packed-BCD ADC/SBC when MPU_DECIMAL_EN is defined.
module mpu6502_lite #(
    parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       RDY,
    input  logic [7:0] DB_IN,
    output logic       R_W,
    output logic [7:0] ABL,
    output logic [7:0] ABH,
    output logic [7:0] DB_OUT
);

    typedef enum logic [2:0] {S_V0, S_V1, S_T0, S_T1, S_T2, S_T3} state_t;
    typedef enum logic [1:0] {M_IMP, M_IMM, M_ZP, M_ABS} mode_t;
    typedef enum logic [5:0] {
        OP_NOP, OP_TAX, OP_TXA, OP_TAY, OP_TYA, OP_TSX, OP_TXS,
        OP_INX, OP_INY, OP_DEX, OP_DEY, OP_CLC, OP_SEC, OP_CLI, OP_SEI,
        OP_CLV, OP_CLD, OP_SED, OP_ASL, OP_LSR, OP_ROL, OP_ROR,
        OP_LDA, OP_LDX, OP_LDY, OP_ADC, OP_SBC, OP_AND, OP_ORA, OP_EOR,
        OP_CMP, OP_CPX, OP_CPY, OP_BIT, OP_STA, OP_STX, OP_STY
    } op_t;

    state_t      r_state, w_state_next;
    logic [7:0]  r_ir, r_a, r_x, r_y, r_s, r_p, r_adl, r_adh;
    logic [15:0] r_pc;

    op_t         w_op;
    mode_t       w_mode;
    logic        w_last, w_store, w_wr, w_set_nz;
    logic [7:0]  w_a, w_x, w_y, w_s, w_p, w_nz_val, w_m_eff, w_cmp_reg, w_wdata;
    logic [7:0]  w_adc_res;
    logic        w_adc_c;
    logic [8:0]  w_sum, w_diff;
    logic [15:0] w_addr;

    // Memory-mode opcodes share one layout: IR[3:2]=01 zero page, 11 absolute, else immediate.
    always_comb begin
        w_op   = OP_NOP;
        w_mode = M_IMP;
        case (r_ir)
            8'hAA: w_op = OP_TAX;  8'h8A: w_op = OP_TXA;  8'hA8: w_op = OP_TAY;
            8'h98: w_op = OP_TYA;  8'hBA: w_op = OP_TSX;  8'h9A: w_op = OP_TXS;
            8'hE8: w_op = OP_INX;  8'hC8: w_op = OP_INY;  8'hCA: w_op = OP_DEX;
            8'h88: w_op = OP_DEY;  8'h18: w_op = OP_CLC;  8'h38: w_op = OP_SEC;
            8'h58: w_op = OP_CLI;  8'h78: w_op = OP_SEI;  8'hB8: w_op = OP_CLV;
            8'hD8: w_op = OP_CLD;  8'hF8: w_op = OP_SED;  8'h0A: w_op = OP_ASL;
            8'h4A: w_op = OP_LSR;  8'h2A: w_op = OP_ROL;  8'h6A: w_op = OP_ROR;
            8'hA9, 8'hA5, 8'hAD: w_op = OP_LDA;
            8'hA2, 8'hA6, 8'hAE: w_op = OP_LDX;
            8'hA0, 8'hA4, 8'hAC: w_op = OP_LDY;
            8'h69, 8'h65, 8'h6D: w_op = OP_ADC;
            8'hE9, 8'hE5, 8'hED: w_op = OP_SBC;
            8'h29, 8'h25, 8'h2D: w_op = OP_AND;
            8'h09, 8'h05, 8'h0D: w_op = OP_ORA;
            8'h49, 8'h45, 8'h4D: w_op = OP_EOR;
            8'hC9, 8'hC5, 8'hCD: w_op = OP_CMP;
            8'hE0, 8'hE4, 8'hEC: w_op = OP_CPX;
            8'hC0, 8'hC4, 8'hCC: w_op = OP_CPY;
            8'h24, 8'h2C:        w_op = OP_BIT;
            8'h85, 8'h8D:        w_op = OP_STA;
            8'h86, 8'h8E:        w_op = OP_STX;
            8'h84, 8'h8C:        w_op = OP_STY;
            default:             w_op = OP_NOP;
        endcase
        if (w_op >= OP_LDA)
            w_mode = (r_ir[3:2] == 2'b01) ? M_ZP : (r_ir[3:2] == 2'b11) ? M_ABS : M_IMM;
    end

    assign w_store = (w_op == OP_STA) || (w_op == OP_STX) || (w_op == OP_STY);
    assign w_last  = ((r_state == S_T1) && ((w_mode == M_IMP) || (w_mode == M_IMM))) ||
                     ((r_state == S_T2) && (w_mode == M_ZP)) ||
                     ((r_state == S_T3) && (w_mode == M_ABS));

    assign w_m_eff   = (w_op == OP_SBC) ? ~DB_IN : DB_IN;
    assign w_sum     = {1'b0, r_a} + {1'b0, w_m_eff} + {8'd0, r_p[0]};
    assign w_cmp_reg = (w_op == OP_CPX) ? r_x : (w_op == OP_CPY) ? r_y : r_a;
    assign w_diff    = {1'b0, w_cmp_reg} + {1'b0, ~DB_IN} + 9'd1;

`ifdef MPU_DECIMAL_EN
    logic [4:0] w_lo, w_hi;
    logic [5:0] w_slo, w_shi;
    logic       w_sbl;
    // BCD result replaces the binary sum; V always comes from the binary path.
    always_comb begin
        w_adc_res = w_sum[7:0];
        w_adc_c   = w_sum[8];
        w_lo = {1'b0, r_a[3:0]} + {1'b0, DB_IN[3:0]} + {4'd0, r_p[0]};
        if (w_lo > 5'd9) w_lo = w_lo + 5'd6;
        w_hi = {1'b0, r_a[7:4]} + {1'b0, DB_IN[7:4]} + {4'd0, w_lo[4]};
        if (w_hi > 5'd9) w_hi = w_hi + 5'd6;
        w_slo = {2'b0, r_a[3:0]} - {2'b0, DB_IN[3:0]} - {5'd0, ~r_p[0]};
        w_sbl = w_slo[5];
        if (w_sbl) w_slo = w_slo - 6'd6;
        w_shi = {2'b0, r_a[7:4]} - {2'b0, DB_IN[7:4]} - {5'd0, w_sbl};
        if (w_shi[5]) w_shi = w_shi - 6'd6;
        if (r_p[3]) begin
            if (w_op == OP_SBC) begin
                w_adc_res = {w_shi[3:0], w_slo[3:0]};
            end else begin
                w_adc_res = {w_hi[3:0], w_lo[3:0]};
                w_adc_c   = w_hi[4];
            end
        end
    end
`else
    always_comb begin
        w_adc_res = w_sum[7:0];
        w_adc_c   = w_sum[8];
    end
`endif

    always_comb begin
        w_a = r_a; w_x = r_x; w_y = r_y; w_s = r_s; w_p = r_p;
        w_set_nz = 1'b1;
        w_nz_val = 8'h00;
        case (w_op)
            OP_TAX: begin w_x = r_a; w_nz_val = r_a; end
            OP_TXA: begin w_a = r_x; w_nz_val = r_x; end
            OP_TAY: begin w_y = r_a; w_nz_val = r_a; end
            OP_TYA: begin w_a = r_y; w_nz_val = r_y; end
            OP_TSX: begin w_x = r_s; w_nz_val = r_s; end
            OP_TXS: begin w_s = r_x; w_set_nz = 1'b0; end
            OP_INX: begin w_x = r_x + 8'd1; w_nz_val = w_x; end
            OP_INY: begin w_y = r_y + 8'd1; w_nz_val = w_y; end
            OP_DEX: begin w_x = r_x - 8'd1; w_nz_val = w_x; end
            OP_DEY: begin w_y = r_y - 8'd1; w_nz_val = w_y; end
            OP_CLC: begin w_p[0] = 1'b0; w_set_nz = 1'b0; end
            OP_SEC: begin w_p[0] = 1'b1; w_set_nz = 1'b0; end
            OP_CLI: begin w_p[2] = 1'b0; w_set_nz = 1'b0; end
            OP_SEI: begin w_p[2] = 1'b1; w_set_nz = 1'b0; end
            OP_CLV: begin w_p[6] = 1'b0; w_set_nz = 1'b0; end
            OP_CLD: begin w_p[3] = 1'b0; w_set_nz = 1'b0; end
            OP_SED: begin w_p[3] = 1'b1; w_set_nz = 1'b0; end
            OP_ASL: begin w_a = {r_a[6:0], 1'b0};   w_p[0] = r_a[7]; w_nz_val = w_a; end
            OP_LSR: begin w_a = {1'b0, r_a[7:1]};   w_p[0] = r_a[0]; w_nz_val = w_a; end
            OP_ROL: begin w_a = {r_a[6:0], r_p[0]}; w_p[0] = r_a[7]; w_nz_val = w_a; end
            OP_ROR: begin w_a = {r_p[0], r_a[7:1]}; w_p[0] = r_a[0]; w_nz_val = w_a; end
            OP_LDA: begin w_a = DB_IN; w_nz_val = DB_IN; end
            OP_LDX: begin w_x = DB_IN; w_nz_val = DB_IN; end
            OP_LDY: begin w_y = DB_IN; w_nz_val = DB_IN; end
            OP_AND: begin w_a = r_a & DB_IN; w_nz_val = w_a; end
            OP_ORA: begin w_a = r_a | DB_IN; w_nz_val = w_a; end
            OP_EOR: begin w_a = r_a ^ DB_IN; w_nz_val = w_a; end
            OP_ADC, OP_SBC: begin
                w_a      = w_adc_res;
                w_p[0]   = w_adc_c;
                w_p[6]   = (r_a[7] == w_m_eff[7]) && (w_sum[7] != r_a[7]);
                w_nz_val = w_adc_res;
            end
            OP_CMP, OP_CPX, OP_CPY: begin w_p[0] = w_diff[8]; w_nz_val = w_diff[7:0]; end
            OP_BIT: begin
                w_set_nz = 1'b0;
                w_p[7] = DB_IN[7];
                w_p[6] = DB_IN[6];
                w_p[1] = ((r_a & DB_IN) == 8'h00);
            end
            default: w_set_nz = 1'b0;
        endcase
        if (w_set_nz) begin
            w_p[7] = w_nz_val[7];
            w_p[1] = (w_nz_val == 8'h00);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_V0:    w_state_next = S_V1;
            S_V1:    w_state_next = S_T0;
            S_T0:    w_state_next = S_T1;
            S_T1:    w_state_next = ((w_mode == M_IMP) || (w_mode == M_IMM)) ? S_T0 : S_T2;
            S_T2:    w_state_next = (w_mode == M_ZP) ? S_T0 : S_T3;
            S_T3:    w_state_next = S_T0;
            default: w_state_next = S_V0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES)      r_state <= S_V0;
        else if (RDY) r_state <= w_state_next;
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            r_a <= '0; r_x <= '0; r_y <= '0; r_s <= 8'hFD; r_p <= 8'h34;
            r_pc <= '0; r_ir <= '0; r_adl <= '0; r_adh <= '0;
        end else if (RDY) begin
            if (w_last) begin
                r_a <= w_a; r_x <= w_x; r_y <= w_y; r_s <= w_s; r_p <= w_p;
            end
            case (r_state)
                S_V0: r_pc[7:0]  <= DB_IN;
                S_V1: r_pc[15:8] <= DB_IN;
                S_T0: begin r_ir <= DB_IN; r_pc <= r_pc + 16'd1; end
                S_T1: if (w_mode != M_IMP) begin r_adl <= DB_IN; r_pc <= r_pc + 16'd1; end
                S_T2: if (w_mode == M_ABS) begin r_adh <= DB_IN; r_pc <= r_pc + 16'd1; end
                default: ;
            endcase
        end
    end

    // Bus outputs depend only on registered state, so a frozen core holds them.
    always_comb begin
        w_addr  = r_pc;
        w_wr    = 1'b0;
        w_wdata = (w_op == OP_STX) ? r_x : (w_op == OP_STY) ? r_y : r_a;
        case (r_state)
            S_V0: w_addr = RESET_VECTOR;
            S_V1: w_addr = RESET_VECTOR + 16'd1;
            S_T2: if (w_mode == M_ZP) begin
                      w_addr = {8'h00, r_adl};
                      w_wr   = w_store;
                  end
            S_T3: begin w_addr = {r_adh, r_adl}; w_wr = w_store; end
            default: w_addr = r_pc;
        endcase
    end

    assign ABL    = w_addr[7:0];
    assign ABH    = w_addr[15:8];
    assign R_W    = ~w_wr;
    assign DB_OUT = w_wr ? w_wdata : 8'h00;

endmodule

// File: tb/tb_mpu6502_lite.sv
// Directed bench for mpu6502_lite: write-cycle scoreboard plus register/bus spot checks.
module tb_mpu6502_lite;

    logic        CLK = 1'b0;
    logic        RES = 1'b1;
    logic        RDY = 1'b1;
    logic [7:0]  DB_IN;
    logic        R_W;
    logic [7:0]  ABL, ABH, DB_OUT;
    logic [15:0] w_addr;
    logic [7:0]  mem [0:65535];

    typedef struct {logic [15:0] a; logic [7:0] d;} wr_t;
    wr_t exp_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_wr = 0;
    int last_wr_cyc = 0;

    mpu6502_lite #(.RESET_VECTOR(16'hFFFC)) dut (
        .CLK(CLK), .RES(RES), .RDY(RDY), .DB_IN(DB_IN),
        .R_W(R_W), .ABL(ABL), .ABH(ABH), .DB_OUT(DB_OUT)
    );

    always #5 CLK = ~CLK;

    assign w_addr = {ABH, ABL};
    assign DB_IN  = mem[w_addr];

    always @(posedge CLK) if (R_W === 1'b0 && RDY) mem[w_addr] = DB_OUT;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every completing write cycle pops one expected {addr,data}.
    always @(negedge CLK) begin : monitor
        wr_t e;
        if (RDY && R_W === 1'b0) begin
            n_wr++;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", w_addr, DB_OUT);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", w_addr, e.a);
                chk("wr_data", {8'h00, DB_OUT}, {8'h00, e.d});
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Clears memory, sets reset vector to 0200 and loads n bytes (first byte = MSB end).
    task automatic prog(input logic [127:0] b, input int n);
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'h02;
        for (int i = 0; i < n; i++) mem[16'(32'h0200 + i)] = b[8*(n-1-i) +: 8];
    endtask

    // Leaves the bench at the start of cycle 1 (V0) after reset release.
    task automatic do_reset();
        RES = 1'b1;
        RDY = 1'b1;
        step();
        step();
        RES = 1'b0;
        cyc = 1;
        n_wr = 0;
        last_wr_cyc = 0;
    endtask

    task automatic drain(input int c);
        run_to(c);
        chk("queue_drain", 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // LDA #7F; ADC #01; STA 0300
        prog(128'hA97F69018D0003, 7);
        expect_wr(16'h0300, 8'h80);
        do_reset();
        chk("rst_addr", w_addr, 16'hFFFC);
        chk("rst_rw", {15'd0, R_W}, 16'd1);
        chk("rst_dbout", {8'h00, DB_OUT}, 16'h0000);
        chk("rst_a", {8'h00, dut.r_a}, 16'h0000);
        chk("rst_s", {8'h00, dut.r_s}, 16'h00FD);
        chk("rst_p", {8'h00, dut.r_p}, 16'h0034);
        step();
        chk("vec_hi_addr", w_addr, 16'hFFFD);
        step();
        chk("first_fetch", w_addr, 16'h0200);
        run_to(7);
        chk("third_fetch", w_addr, 16'h0204);
        chk("adc_a", {8'h00, dut.r_a}, 16'h0080);
        chk("adc_p", {8'h00, dut.r_p}, 16'h00F4);
        drain(14);

        // LDX #FF; INX; TAX; ASL A; STX 40; STA 41
        prog(128'hA2FFE8AA0A86408541, 9);
        expect_wr(16'h0040, 8'h00);
        expect_wr(16'h0041, 8'h00);
        do_reset();
        run_to(11);
        chk("inx_x", {8'h00, dut.r_x}, 16'h0000);
        chk("asl_p", {8'h00, dut.r_p}, 16'h0036);
        drain(20);

        // LDA 10; EOR #FF; STA 0300
        prog(128'hA51049FF8D0003, 7);
        mem[16'h0010] = 8'h55;
        expect_wr(16'h0300, 8'hAA);
        do_reset();
        drain(15);
        chk("sta_one_write", 16'(n_wr), 16'd1);
        chk("sta_write_cycle", 16'(last_wr_cyc), 16'd11);
        chk("mem_0300", {8'h00, mem[16'h0300]}, 16'h00AA);

        // SEC; LDA #50; SBC #F0; STA 42; SED; CLC; LDA #15; ADC #27; STA 43
        prog(128'h38A950E9F08542F818A91569278543, 15);
        expect_wr(16'h0042, 8'h60);
`ifdef MPU_DECIMAL_EN
        expect_wr(16'h0043, 8'h42);
`else
        expect_wr(16'h0043, 8'h3C);
`endif
        do_reset();
        run_to(9);
        chk("sbc_p", {8'h00, dut.r_p}, 16'h0034);
        drain(28);
        chk("adc_d_p", {8'h00, dut.r_p}, 16'h003C);

        // LDY #40; CPY #41; BIT 20; STY 50
        prog(128'hA040C04124208450, 8);
        mem[16'h0020] = 8'hC0;
        expect_wr(16'h0050, 8'h40);
        do_reset();
        run_to(7);
        chk("cpy_p", {8'h00, dut.r_p}, 16'h00B4);
        run_to(10);
        chk("bit_p", {8'h00, dut.r_p}, 16'h00F6);
        drain(16);

        // TSX; STX 44; DEX; STX 45; undefined 02; LDA #81; LSR; ROR; STA 46
        prog(128'hBA8644CA864502A9814A6A8546, 13);
        expect_wr(16'h0044, 8'hFD);
        expect_wr(16'h0045, 8'hFC);
        expect_wr(16'h0046, 8'hA0);
        do_reset();
        drain(27);
        chk("shift_p", {8'h00, dut.r_p}, 16'h00B4);
        chk("undef_timing", 16'(last_wr_cyc), 16'd23);
        chk("three_writes", 16'(n_wr), 16'd3);

        // LDA 1234 with RDY low for 3 cycles during the high-byte fetch; STA 60
        prog(128'hAD34128560, 5);
        mem[16'h1234] = 8'h5A;
        expect_wr(16'h0060, 8'h5A);
        do_reset();
        run_to(5);
        RDY = 1'b0;
        chk("rdy_addr_c5", w_addr, 16'h0202);
        step();
        chk("rdy_addr_c6", w_addr, 16'h0202);
        step();
        chk("rdy_addr_c7", w_addr, 16'h0202);
        step();
        chk("rdy_addr_c8", w_addr, 16'h0202);
        RDY = 1'b1;
        drain(16);
        chk("rdy_write_cycle", 16'(last_wr_cyc), 16'd12);

        // Reset during the LDA abs high-byte fetch
        prog(128'hAD3412, 3);
        do_reset();
        run_to(5);
        RES = 1'b1;
        step();
        chk("abort_v0", w_addr, 16'hFFFC);
        RES = 1'b0;
        step();
        chk("abort_v1", w_addr, 16'hFFFD);
        step();
        chk("abort_refetch", w_addr, 16'h0200);

        // Reset sampled during an STA zp write cycle: that write still happens
        prog(128'h8570, 2);
        mem[16'h0070] = 8'hEE;
        expect_wr(16'h0070, 8'h00);
        do_reset();
        run_to(5);
        RES = 1'b1;
        chk("wr_under_res", {15'd0, R_W}, 16'd0);
        step();
        chk("res_rw", {15'd0, R_W}, 16'd1);
        chk("res_addr", w_addr, 16'hFFFC);
        RES = 1'b0;
        drain(9);
        chk("mem_0070", {8'h00, mem[16'h0070]}, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
